// File: rtl/instr_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Purpose : Shared types and helpers for the loadable instruction memory.
//           Holds the controller state enum, the default fill word, and the
//           byte-address -> word-index and legality helpers.
// Revision: 1.0 - initial release
// ============================================================================
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

  // Word index of a byte address: bits [idx_w:1].
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int idx_w);
    return (addr >> 1) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // A byte address is usable when it is halfword aligned and inside the array.
  function automatic logic addr_legal(input logic [31:0] addr, input int depth);
    return (addr[0] == 1'b0) && (addr < (depth << 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_ctrl_if
// Purpose : Load (boot loader) and fetch bus of the instruction memory.
//   master : drives ld_en/ld_addr/ld_data/ld_done, fetch_req/fetch_pc/
//            fetch_stall; observes ld_err, boot_busy, fetch_ready,
//            fetch_valid, fetch_instr, fetch_fault
//   slave  : the memory controller side (mirror of master)
// Revision: 1.0 - initial release
// ============================================================================
interface instr_mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              ld_err;
  logic              boot_busy;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_stall;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_fault;

  modport master (
    output ld_en, ld_addr, ld_data, ld_done, fetch_req, fetch_pc, fetch_stall,
    input  ld_err, boot_busy, fetch_ready, fetch_valid, fetch_instr, fetch_fault
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, ld_done, fetch_req, fetch_pc, fetch_stall,
    output ld_err, boot_busy, fetch_ready, fetch_valid, fetch_instr, fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_ctrl_array.sv
`default_nettype none
// ============================================================================
// Module  : imem_array
// Purpose : DEPTH x DATA_W storage, one synchronous write port and one
//           registered read port. A read to the word being written in the
//           same cycle returns the new data. i_re=0 holds o_rdata.
//   clk     : clock
//   i_we    : write enable        i_waddr/i_wdata : write word index/data
//   i_re    : read enable         i_raddr         : read word index
//   o_rdata : registered read data
// Revision: 1.0 - initial release
// ============================================================================
module imem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              i_we,
  input  wire logic [IDX_W-1:0]  i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_re,
  input  wire logic [IDX_W-1:0]  i_raddr,
  output logic      [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are initialised by the controller's sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_ctrl
// Purpose : Loadable instruction memory with registered fetch port.
//           After reset the array is swept to NOP_WORD (CLEAR), then filled
//           by the boot loader (LOAD), then serves fetches (RUN) with 1-cycle
//           latency, stall hold and fault substitution.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : load + fetch bus (slave side)
// Revision: 1.0 - initial release
// ============================================================================
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input wire logic        clk,
  input wire logic        rst_n,
  instr_mem_ctrl_if.slave bus
);

  localparam int              IDX_W      = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_ld_err;
  logic              r_fetch_valid;
  logic              r_fetch_fault;
  // Selects NOP_WORD instead of the array read register on the output; this
  // keeps a faulted NOP (or the reset NOP) stable while fetch_instr holds.
  logic              r_sel_nop;

  logic              w_ld_legal;
  logic              w_fetch_legal;
  logic              w_fetch_ready;
  logic              w_accept;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_re;
  logic [IDX_W-1:0]  w_raddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_ld_legal    = addr_legal(32'(bus.ld_addr), DEPTH);
  assign w_fetch_legal = addr_legal(32'(bus.fetch_pc), DEPTH);
  assign w_fetch_ready = (r_state == RUN) && !bus.fetch_stall;
  assign w_accept      = bus.fetch_req && w_fetch_ready;
  assign w_raddr       = IDX_W'(word_idx(32'(bus.fetch_pc), IDX_W));
  // Faulted fetches never touch the array; the output shows NOP_WORD instead.
  assign w_re          = w_accept && w_fetch_legal;

  // Write port: the sweep owns it in CLEAR, the loader afterwards.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_cnt;
    w_wdata = NOP_WORD;
    if (r_state == CLEAR) begin
      w_we = 1'b1;
    end else begin
      w_we    = bus.ld_en && w_ld_legal;
      w_waddr = IDX_W'(word_idx(32'(bus.ld_addr), IDX_W));
      w_wdata = bus.ld_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_cnt == C_LAST_IDX) w_state_next = LOAD;
      LOAD:    if (bus.ld_done) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= CLEAR;
      r_clr_cnt     <= '0;
      r_ld_err      <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_sel_nop     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + IDX_W'(1);
      end
      r_ld_err <= bus.ld_en && ((r_state == CLEAR) || !w_ld_legal);
      if (!bus.fetch_stall) begin
        r_fetch_valid <= w_accept;
        r_fetch_fault <= w_accept && !w_fetch_legal;
        if (w_accept) begin
          r_sel_nop <= !w_fetch_legal;
        end
      end
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.ld_err      = r_ld_err;
  assign bus.boot_busy   = (r_state != RUN);
  assign bus.fetch_ready = w_fetch_ready;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_fault = r_fetch_fault;
  assign bus.fetch_instr = r_sel_nop ? NOP_WORD : w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_mem_ctrl
// Purpose : Directed self-checking bench for instr_mem_ctrl (DEPTH=32).
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic        fault;
    logic        ld_err;
    logic        busy;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  exp_t        sb_q[$];
  logic [15:0] m_mem[32];
  int          m_state;   // 0 CLEAR, 1 LOAD, 2 RUN
  int          m_cnt;
  logic        m_valid;
  logic        m_fault;
  logic [15:0] m_instr;

  instr_mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  instr_mem_ctrl #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEPTH    (32),
    .NOP_WORD (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    m_instr = 16'h0000;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " valid"},  32'(bus.fetch_valid), 32'd0);
    chk({tag, " instr"},  32'(bus.fetch_instr), 32'h0000);
    chk({tag, " fault"},  32'(bus.fetch_fault), 32'd0);
    chk({tag, " busy"},   32'(bus.boot_busy),   32'd1);
    chk({tag, " ld_err"}, 32'(bus.ld_err),      32'd0);
  endtask

  // One clock cycle: drive inputs, check fetch_ready, predict the post-edge
  // outputs into the scoreboard, clock, then pop and compare.
  task automatic step(input logic ld_en, input logic [15:0] ld_addr,
                      input logic [15:0] ld_data, input logic ld_done,
                      input logic req, input logic [15:0] pc,
                      input logic stall, input string tag);
    exp_t e;
    exp_t got;
    logic ready_exp;
    logic legal_ld;
    logic legal_f;
    bus.ld_en       = ld_en;
    bus.ld_addr     = ld_addr;
    bus.ld_data     = ld_data;
    bus.ld_done     = ld_done;
    bus.fetch_req   = req;
    bus.fetch_pc    = pc;
    bus.fetch_stall = stall;
    #1;
    ready_exp = (m_state == 2) && !stall;
    chk({tag, " ready"}, 32'(bus.fetch_ready), 32'(ready_exp));

    legal_ld = !ld_addr[0] && (ld_addr < 16'd64);
    e.ld_err = ld_en && ((m_state == 0) || !legal_ld);
    if (ld_en && legal_ld && (m_state != 0)) m_mem[ld_addr[5:1]] = ld_data;
    if (req && ready_exp) begin
      legal_f = !pc[0] && (pc < 16'd64);
      m_valid = 1'b1;
      m_fault = !legal_f;
      m_instr = legal_f ? m_mem[pc[5:1]] : 16'h0000;
    end else if (!stall) begin
      m_valid = 1'b0;
      m_fault = 1'b0;
    end
    if (m_state == 0) begin
      m_mem[m_cnt] = 16'h0000;
      if (m_cnt == 31) m_state = 1;
      m_cnt++;
    end else if ((m_state == 1) && ld_done) begin
      m_state = 2;
    end
    e.valid = m_valid;
    e.instr = m_instr;
    e.fault = m_fault;
    e.busy  = (m_state != 2);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, " valid"},  32'(bus.fetch_valid), 32'(got.valid));
    chk({tag, " instr"},  32'(bus.fetch_instr), 32'(got.instr));
    chk({tag, " fault"},  32'(bus.fetch_fault), 32'(got.fault));
    chk({tag, " ld_err"}, 32'(bus.ld_err),      32'(got.ld_err));
    chk({tag, " busy"},   32'(bus.boot_busy),   32'(got.busy));
  endtask

  task automatic fetch(input logic [15:0] pc, input string tag);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, pc, 1'b0, tag);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d, input string tag);
    step(1'b1, a, d, 1'b0, 1'b0, 16'h0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 16'h5A5A;
    model_reset();
    rst_n           = 1'b0;
    bus.ld_en       = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.ld_done     = 1'b0;
    bus.fetch_req   = 1'b0;
    bus.fetch_pc    = '0;
    bus.fetch_stall = 1'b0;

    @(posedge clk);
    #1;
    check_reset_values("reset");
    chk("reset ready", 32'(bus.fetch_ready), 32'd0);
    rst_n = 1'b1;

    // CLEAR: exactly 32 cycles; fetches refused, ld_done ignored, and a load
    // in the final CLEAR cycle is rejected.
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 16'h0004, 16'hDEAD, i == 3, 1'b1, 16'h0000, 1'b0, "clear");
    end

    // LOAD: first LOAD-cycle write must be accepted without error.
    load(16'h0000, 16'h1053, "load0");
    load(16'h0022, 16'h8085, "load22");
    step(1'b1, 16'h003E, 16'h7777, 1'b1, 1'b0, 16'h0, 1'b0, "load_done");

    // Back-to-back fetches.
    fetch(16'h0000, "f00");
    fetch(16'h0022, "f22");
    fetch(16'h003E, "f3e");

    // Faults and defaults.
    fetch(16'h0004, "f04_unwritten");
    fetch(16'h0040, "f40_range");
    fetch(16'h0003, "f03_misalign");
    idle("idle_hold");
    load(16'h0041, 16'hBEEF, "ld41_bad");
    fetch(16'h0000, "f00_after_bad");

    // Stall hold.
    fetch(16'h0000, "stall_pre");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0022, 1'b1, "stall");
    end
    fetch(16'h0022, "stall_rel");
    idle("idle2");

    // Write-first collision, then refetch.
    step(1'b1, 16'h0002, 16'hABCD, 1'b0, 1'b1, 16'h0002, 1'b0, "wfirst");
    fetch(16'h0002, "refetch");

    // Async reset between edges in RUN.
    fetch(16'h0022, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) idle("reclear");
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, "done2");
    fetch(16'h0000, "f00_cleared");
    fetch(16'h0022, "f22_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised, loadable instruction memory with a registered fetch port; successor to the fixed 32x16 combinational ROM. After reset the array is swept to NOP, then a boot loader fills it through a byte-addressed load port. Fetch then runs with 1-cycle read latency, stall/hold, and fault flags for misaligned or out-of-range PCs. Sits between the PC/fetch stage and the decode stage.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 16, PC / load address width (byte address)
DEPTH, 32, number of words; power of 2, >= 2
NOP_WORD, 16'h0000, fill value and value returned on fault

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_en  in  1  load-write strobe
ld_addr  in  ADDR_W  load byte address; word index = ld_addr[IDX_W:1], IDX_W=log2(DEPTH)
ld_data  in  DATA_W  load data
ld_done  in  1  end-of-boot pulse
ld_err  out  1  1-cycle pulse: rejected load write
boot_busy  out  1  high in CLEAR and LOAD
fetch_req  in  1  fetch request
fetch_pc  in  ADDR_W  fetch byte address
fetch_stall  in  1  downstream stall: hold outputs, refuse requests
fetch_ready  out  1  combinational: (state==RUN) & !fetch_stall
fetch_valid  out  1  registered instruction valid
fetch_instr  out  DATA_W  registered instruction
fetch_fault  out  1  registered: instruction replaced by NOP_WORD

Behaviour:
- Reset (async, rst_n=0): state=CLEAR, clr_cnt=0, fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0, ld_err=0, boot_busy=1. Array contents are not reset directly; CLEAR overwrites them.
- Reset mid-operation: immediate return to the reset values. The array is recleared and must be reloaded.
- CLEAR: writes NOP_WORD to word clr_cnt each cycle, then increments clr_cnt. After the write at clr_cnt=DEPTH-1, state moves to LOAD. CLEAR lasts exactly DEPTH cycles. ld_en is not written; it produces an ld_err pulse next cycle. ld_done is ignored.
- Load address legality: legal iff ld_addr[0]=0 and ld_addr < 2*DEPTH.
- LOAD: ld_en with a legal address writes ld_data at the next edge. An illegal address causes no write and an ld_err pulse next cycle. ld_done moves state to RUN next cycle. If ld_en and ld_done are asserted together, the write is performed, then RUN.
- RUN: ld_done is ignored. ld_en is still honoured with the same legality rules (runtime patching).
- Fetch accept: fetch_req & fetch_ready. fetch_ready=0 in CLEAR and LOAD.
- Accepted fetch: at the next edge, fetch_valid=1.
  - Normal: fetch_instr = word[fetch_pc[IDX_W:1]], fetch_fault=0.
  - Misaligned PC (fetch_pc[0]=1) or out-of-range PC (fetch_pc >= 2*DEPTH): fetch_instr=NOP_WORD, fetch_fault=1.
- Back-to-back fetches give one instruction per cycle.
- No accept and fetch_stall=0: next edge fetch_valid=0, fetch_fault=0; fetch_instr holds its last value.
- fetch_stall=1: fetch_valid, fetch_instr and fetch_fault all hold. No array read is launched.
- Write/fetch collision: load write and accepted fetch to the same word in the same cycle returns the new ld_data (write-first).
- State machine: CLEAR -> LOAD (clr_cnt==DEPTH-1) -> RUN (ld_done) -> RUN. Leaving RUN is possible only through reset.

Decomposition:
- Package imem_pkg:
  - state enum {CLEAR, LOAD, RUN}
  - default NOP_WORD
  - function word_idx(addr, IDX_W)
  - function addr_legal(addr, DEPTH)
- Sub-module imem_array: DEPTH x DATA_W, one synchronous write port, one synchronous read port, write-first bypass, read-enable input for stall hold.
- All sequencing (CLEAR counter, FSM, fault logic, output hold) lives in instr_mem_ctrl.

Test Plan:
1. CLEAR timing: release rst_n with DEPTH=32 -> boot_busy high, state CLEAR for exactly 32 cycles, then LOAD. ld_en during CLEAR -> ld_err pulse, no write.
2. Load and fetch: load 16'h1053 @0x00 and 16'h8085 @0x22, then ld_done. Fetch pc 0x00 then 0x22 back-to-back -> fetch_valid 1 on consecutive cycles, instr 1053 then 8085, fault 0.
3. Faults and defaults:
   - fetch unwritten pc 0x04 -> 0000, fault 0
   - fetch pc 0x40 -> 0000, fault 1
   - fetch pc 0x03 -> 0000, fault 1
   - ld_en @0x41 -> ld_err pulse, no write
4. Stall: fetch pc 0x00, then fetch_stall=1 for 3 cycles with req high, pc 0x22 -> fetch_ready 0, outputs hold 1053/valid 1. Release stall -> next cycle fetch_instr 8085.
5. Write-first: in RUN, ld_en @0x02 data ABCD in the same cycle as fetch pc 0x02 -> fetch_instr ABCD. A refetch also returns ABCD.
6. Async reset mid-RUN: drop rst_n between edges -> fetch_valid 0, fetch_instr 0000, boot_busy 1 immediately. After CLEAR, ld_done with no loads, then fetch pc 0x00 -> 0000 (array recleared).
